// File: rtl/ieee754_pkg.sv
// Shared constants and types for the IEEE-754 single-precision operation sequencer.
package ieee754_pkg;

  // Operation select encoding understood by the downstream FP unit
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Single-precision field geometry
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Bit positions inside the 5-bit class vector {sign, nan, inf, zero, denorm}
  localparam int FLAG_SIGN   = 4;
  localparam int FLAG_NAN    = 3;
  localparam int FLAG_INF    = 2;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_DENORM = 0;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/ieee754_classify.sv
// Combinational classifier: maps a single-precision word to {sign, nan, inf, zero, denorm}.
module ieee754_classify
  import ieee754_pkg::*;
(
  input  logic [31:0] x_i,
  output logic [4:0]  flags_o
);

  logic [EXP_W-1:0] exp_field;
  logic             man_nz;

  assign exp_field = x_i[MAN_W +: EXP_W];
  assign man_nz    = |x_i[MAN_W-1:0];

  // At most one of the class bits is set; a normal number leaves all four clear
  always_comb begin
    flags_o            = '0;
    flags_o[FLAG_SIGN] = x_i[31];
    if (exp_field == '0) begin
      flags_o[FLAG_ZERO]   = ~man_nz;
      flags_o[FLAG_DENORM] = man_nz;
    end else if (exp_field == EXP_MAX) begin
      flags_o[FLAG_INF] = ~man_nz;
      flags_o[FLAG_NAN] = man_nz;
    end
  end

endmodule

// File: rtl/ieee754_op_sequencer.sv
// Control stage for a combinational FP unit: accept a command, drive the unit,
// wait a fixed settle interval, capture and classify the result, hand it off.
module ieee754_op_sequencer
  import ieee754_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_op,
  output logic [31:0]      fp_a,
  output logic [31:0]      fp_b,
  output logic [1:0]       fp_op,
  input  logic [31:0]      fp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags,
  output logic [CNT_W-1:0] op_count
);

  // Counter is loaded with SETTLE_CYCLES-1 so the capture lands exactly
  // SETTLE_CYCLES edges after acceptance
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  seq_state_e       state_q;
  logic [3:0]       settle_q;
  logic [31:0]      fp_a_q;
  logic [31:0]      fp_b_q;
  logic [1:0]       fp_op_q;
  logic [31:0]      out_result_q;
  logic [4:0]       out_flags_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] op_count_q;
  logic [4:0]       result_flags;

  ieee754_classify u_classify (
    .x_i     (fp_result),
    .flags_o (result_flags)
  );

  // Single control FSM; every output is a register or a direct state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      fp_a_q       <= '0;
      fp_b_q       <= '0;
      fp_op_q      <= OP_ADD;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_valid_q  <= 1'b0;
      op_count_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            fp_a_q   <= in_a;
            fp_b_q   <= in_b;
            fp_op_q  <= in_op;
            settle_q <= SETTLE_LOAD;
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == 4'd0) begin
            out_result_q <= fp_result;
            out_flags_q  <= result_flags;
            out_valid_q  <= 1'b1;
            state_q      <= ST_HOLD;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            op_count_q  <= op_count_q + CNT_ONE;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign fp_a       = fp_a_q;
  assign fp_b       = fp_b_q;
  assign fp_op      = fp_op_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_ieee754_op_sequencer.sv
// Scoreboard bench: two sequencer instances (16-bit and 2-bit counters) share
// stimulus; a behavioural FP-unit stand-in closes each loop.
module tb_ieee754_op_sequencer;
  import ieee754_pkg::*;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_op = '0;
  logic        stub_en = 1'b0;
  logic [31:0] stub_val = '0;

  logic        in_ready, out_valid;
  logic [31:0] fp_a, fp_b, fp_res, out_result;
  logic [1:0]  fp_op;
  logic [4:0]  out_flags;
  logic [15:0] op_count;

  logic        in_ready_2, out_valid_2;
  logic [31:0] fp_a_2, fp_b_2, fp_res_2, out_result_2;
  logic [1:0]  fp_op_2;
  logic [4:0]  out_flags_2;
  logic [1:0]  op_count_2;

  // Stand-in for the FP unit: exact answers for the known operand pairs,
  // otherwise a deterministic scramble steered across all value classes
  function automatic logic [31:0] unit_fn(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    logic [31:0] h;
    if (a == 32'h40980000 && b == 32'h40080000 && op == OP_ADD) return 32'h40DC0000;
    if (a == 32'h40980000 && b == 32'h40080000 && op == OP_MUL) return 32'h41218000;
    if (a == 32'h41180000 && b == 32'h41180000 && op == OP_SUB) return 32'h00000000;
    h = (a ^ {b[15:0], b[31:16]}) + ({30'd0, op} + 32'd1) * 32'h9E3779B9;
    if (op == OP_DIV) h = ~h;
    case (h[1:0])
      2'd0: h[30:23] = 8'h00;
      2'd1: h[30:23] = 8'hFF;
      default: ;
    endcase
    if (h[2] && !h[1]) h[22:0] = '0;
    return h;
  endfunction

  // Reference classification, straight from the field rules
  function automatic logic [4:0] ref_flags(logic [31:0] x);
    int e;
    int m;
    logic s, nan, inf, zero, den;
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    s = x[31];
    zero = (e == 0)   && (m == 0);
    den  = (e == 0)   && (m != 0);
    inf  = (e == 255) && (m == 0);
    nan  = (e == 255) && (m != 0);
    return {s, nan, inf, zero, den};
  endfunction

  assign fp_res   = stub_en ? stub_val : unit_fn(fp_a, fp_b, fp_op);
  assign fp_res_2 = stub_en ? stub_val : unit_fn(fp_a_2, fp_b_2, fp_op_2);

  ieee754_op_sequencer #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .fp_a(fp_a), .fp_b(fp_b), .fp_op(fp_op), .fp_result(fp_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .op_count(op_count)
  );

  ieee754_op_sequencer #(.SETTLE_CYCLES(S), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .fp_a(fp_a_2), .fp_b(fp_b_2), .fp_op(fp_op_2), .fp_result(fp_res_2),
    .out_valid(out_valid_2), .out_ready(out_ready), .out_result(out_result_2),
    .out_flags(out_flags_2), .op_count(op_count_2)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;
  } exp_t;
  exp_t q[$];

  // Transaction-level model state
  bit          busy_m = 1'b0;
  int          acc_cyc = 0;
  int          cnt_m = 0;
  logic [31:0] ma = '0;
  logic [31:0] mb = '0;
  logic [1:0]  mop = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_dut(string tag, logic ir, logic [31:0] fa, logic [31:0] fb,
                           logic [1:0] fo, logic ov, logic [31:0] ores,
                           logic [4:0] ofl, logic [31:0] cnt, logic [31:0] cnt_exp);
    bit ev;
    ev = busy_m && (cyc - acc_cyc >= S);
    chk({tag, ".in_ready"}, 32'(ir), 32'(!busy_m));
    chk({tag, ".out_valid"}, 32'(ov), 32'(ev));
    chk({tag, ".fp_a"}, fa, ma);
    chk({tag, ".fp_b"}, fb, mb);
    chk({tag, ".fp_op"}, 32'(fo), 32'(mop));
    chk({tag, ".op_count"}, cnt, cnt_exp);
    if (ev && q.size() > 0) begin
      chk({tag, ".out_result"}, ores, q[0].res);
      chk({tag, ".out_flags"}, 32'(ofl), 32'(q[0].flags));
    end
    if (!rst_n) begin
      chk({tag, ".rst_result"}, ores, 32'd0);
      chk({tag, ".rst_flags"}, 32'(ofl), 32'd0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: checks every output mid-cycle, then advances the model for the coming edge
  initial forever begin
    bit ev;
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      busy_m = 1'b0;
      q.delete();
      cnt_m = 0;
      ma = '0;
      mb = '0;
      mop = '0;
    end
    check_dut("w16", in_ready, fp_a, fp_b, fp_op, out_valid, out_result, out_flags,
              32'(op_count), 32'(cnt_m % 65536));
    check_dut("w2", in_ready_2, fp_a_2, fp_b_2, fp_op_2, out_valid_2, out_result_2,
              out_flags_2, 32'(op_count_2), 32'(cnt_m % 4));
    if (rst_n) begin
      ev = busy_m && (cyc - acc_cyc >= S);
      if (!busy_m && in_valid) begin
        e.res   = stub_en ? stub_val : unit_fn(in_a, in_b, in_op);
        e.flags = ref_flags(e.res);
        q.push_back(e);
        busy_m  = 1'b1;
        acc_cyc = cyc + 1;
        ma = in_a;
        mb = in_b;
        mop = in_op;
      end else if (ev && out_ready && q.size() > 0) begin
        e = q.pop_front();
        cnt_m++;
        busy_m = 1'b0;
        $display("op %0d: a=%h b=%h op=%0d -> result=%h flags=%b count=%0d",
                 cnt_m, ma, mb, mop, e.res, e.flags, op_count);
      end
    end
  end

  task automatic run_op(logic [31:0] a, logic [31:0] b, logic [1:0] op, int hold);
    int n;
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accept_timeout", 32'(n >= 50), 32'd0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("result_timeout", 32'(n >= 50), 32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while a command is settling: nothing should ever come out of it
    in_a = 32'h3F800000; in_b = 32'h40000000; in_op = OP_MUL;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end

    // Directed FP cases and held output
    run_op(32'h40980000, 32'h40080000, OP_ADD, 0);
    run_op(32'h40980000, 32'h40080000, OP_MUL, 5);
    run_op(32'h41180000, 32'h41180000, OP_SUB, 0);

    // Forced unit results for inf, negative NaN, smallest denormal
    stub_en = 1'b1;
    stub_val = 32'h7F800000; run_op(32'h1, 32'h2, OP_DIV, 0);
    stub_val = 32'hFFC00000; run_op(32'h3, 32'h4, OP_ADD, 1);
    stub_val = 32'h00000001; run_op(32'h5, 32'h6, OP_SUB, 0);
    stub_en = 1'b0;

    // Random handshakes with operands changing every cycle
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_a  = $urandom;
      in_b  = $urandom;
      in_op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end

    // Saturated back-to-back traffic drives the narrow counter through its wrap
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_a  = $urandom;
      in_b  = $urandom;
      in_op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
